// File: rtl/div_ctrl_pkg.sv
// Shared types for the EX-stage divider: ALU opcode encoding, divider FSM states
// and small opcode-decode helpers used by the sequencing controller.
package div_ctrl_pkg;

    localparam int DIV_ITERS = 32;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_NOR   = 5'd5,
        ALU_SLL   = 5'd6,
        ALU_SRL   = 5'd7,
        ALU_SRA   = 5'd8,
        ALU_SLT   = 5'd9,
        ALU_SLTU  = 5'd10,
        ALU_LUI   = 5'd11,
        ALU_MUL   = 5'd12,
        ALU_MULH  = 5'd13,
        ALU_MULHU = 5'd14,
        ALU_DIV   = 5'd15,
        ALU_MOD   = 5'd16,
        ALU_DIVU  = 5'd17,
        ALU_MODU  = 5'd18
    } AluCtrl;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_PREP,
        DIV_ITER,
        DIV_FIX,
        DIV_DONE
    } DivState;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_MOD) || (op == ALU_DIVU) || (op == ALU_MODU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

    // Quotient-producing ops; the other two return the remainder.
    function automatic logic is_quo_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divide datapath on unsigned magnitudes. Sequencing is
// entirely owned by div_ctrl through the load and step strobes.
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            aclk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend_abs,
    input  logic [XLEN-1:0] divisor_abs,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    // The extra top bit of trial acts as the borrow that decides restore vs keep.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {2'b00, divisor_q};
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
        end else if (load) begin
            rem_q     <= '0;
            quo_q     <= dividend_abs;
            divisor_q <= divisor_abs;
        end else if (step) begin
            if (!trial[XLEN+1]) begin
                rem_q <= trial[XLEN:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quo = quo_q;
    assign rem = rem_q[XLEN-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle divide sequencer: latches one request, runs div_core for a fixed
// number of steps, applies sign and divide-by-zero fixups, and holds the result.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = div_ctrl_pkg::DIV_ITERS
) (
    input  logic            aclk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd_no,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      out_rd_no,
    output logic            busy
);

    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

    DivState state, next_state;

    logic [4:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] src1_q;
    logic [XLEN-1:0] src2_q;
    logic            sign_q;
    logic            sign_r;
    logic            div0_q;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      out_rd_q;

    logic            accept;
    logic            core_load;
    logic            core_step;
    logic            s1;
    logic            s2;
    logic [XLEN-1:0] dividend_abs;
    logic [XLEN-1:0] divisor_abs;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] fix_value;

    assign accept = in_valid & in_ready & is_div_op(op) & ~flush;

    div_core #(.XLEN(XLEN)) u_core (
        .aclk         (aclk),
        .reset        (reset),
        .load         (core_load),
        .step         (core_step),
        .dividend_abs (dividend_abs),
        .divisor_abs  (divisor_abs),
        .quo          (quo),
        .rem          (rem)
    );

    always_ff @(posedge aclk) begin
        if (reset) state <= DIV_IDLE;
        else       state <= next_state;
    end

    // flush overrides every transition, including the DONE handshake.
    always_comb begin
        next_state = state;
        unique case (state)
            DIV_IDLE: if (accept) next_state = DIV_PREP;
            DIV_PREP: next_state = DIV_ITER;
            DIV_ITER: if (count_q == LAST_ITER) next_state = DIV_FIX;
            DIV_FIX:  next_state = DIV_DONE;
            DIV_DONE: if (out_ready) next_state = DIV_IDLE;
            default:  next_state = DIV_IDLE;
        endcase
        if (flush) next_state = DIV_IDLE;
    end

    always_comb begin
        in_ready  = (state == DIV_IDLE);
        busy      = (state != DIV_IDLE);
        out_valid = (state == DIV_DONE);
        core_load = (state == DIV_PREP);
        core_step = (state == DIV_ITER);
    end

    // Magnitudes wrap modulo 2^XLEN, so the most negative value maps to itself.
    always_comb begin
        s1           = is_signed_op(op_q) & src1_q[XLEN-1];
        s2           = is_signed_op(op_q) & src2_q[XLEN-1];
        dividend_abs = s1 ? -src1_q : src1_q;
        divisor_abs  = s2 ? -src2_q : src2_q;
    end

    always_comb begin
        fix_value = is_quo_op(op_q) ? (sign_q ? -quo : quo)
                                    : (sign_r ? -rem : rem);
        if (div0_q) fix_value = is_quo_op(op_q) ? '1 : src1_q;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            op_q     <= '0;
            rd_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div0_q   <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            out_rd_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= op;
                rd_q   <= rd_no;
                src1_q <= src1;
                src2_q <= src2;
            end
            if (state == DIV_PREP) begin
                sign_q  <= s1 ^ s2;
                sign_r  <= s1;
                div0_q  <= (src2_q == '0);
                count_q <= '0;
            end
            if (state == DIV_ITER) count_q <= count_q + CNT_W'(1);
            if (state == DIV_FIX && !flush) begin
                result_q <= fix_value;
                out_rd_q <= rd_q;
            end
        end
    end

    assign result    = result_q;
    assign out_rd_no = out_rd_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed corner cases plus randomized ops,
// checked against a plain-arithmetic model of truncating division.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int LATENCY = 34;

    logic        aclk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  rd_no;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_rd_no;
    logic        busy;

    typedef struct {
        logic [31:0] value;
        logic [4:0]  rd;
        int          acc_cycle;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    logic prev_valid = 1'b0;

    div_ctrl dut (
        .aclk      (aclk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .rd_no     (rd_no),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_rd_no (out_rd_no),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference: 64-bit arithmetic, where SV division truncates toward zero.
    function automatic logic [31:0] ref_model(input logic [4:0] op_i, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic   want_quo;
        want_quo = (op_i == ALU_DIV) || (op_i == ALU_DIVU);
        if (b == 32'd0) return want_quo ? 32'hFFFF_FFFF : a;
        if (op_i == ALU_DIV || op_i == ALU_MOD) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return want_quo ? q[31:0] : r[31:0];
    endfunction

    always @(negedge aclk) begin
        exp_t e;
        if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("result", result, e.value);
                check_output("out_rd_no", {27'd0, out_rd_no}, {27'd0, e.rd});
                check_output("latency", cycle - e.acc_cycle, LATENCY);
            end
        end
        prev_valid <= out_valid;
    end

    task automatic apply_stimulus(input logic [4:0] op_i, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge aclk); #1;
            n++;
        end
        if (n >= 100) check_output("accept_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op       = op_i;
        src1     = a;
        src2     = b;
        rd_no    = rd;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        exp_q.push_back('{ref_model(op_i, a, b), rd, cycle});
    endtask

    task automatic wait_idle(input bit rand_ready);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge aclk); #1;
            n++;
        end
        out_ready = 1'b1;
        if (n >= 100) check_output("idle_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [4:0] op_i, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        apply_stimulus(op_i, a, b, rd);
        wait_idle(1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] rop;
        int         n;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = ALU_ADD;
        src1      = '0;
        src2      = '0;
        rd_no     = '0;
        repeat (2) @(posedge aclk);
        #1;
        check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst_result", result, 32'd0);
        check_output("rst_out_rd_no", {27'd0, out_rd_no}, 32'd0);
        reset = 1'b0;

        run_op(ALU_DIVU, 32'd100, 32'd7, 5'd3);
        run_op(ALU_MODU, 32'd100, 32'd7, 5'd4);
        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);
        run_op(ALU_MOD, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op(ALU_DIV, 32'd7, 32'hFFFF_FFFE, 5'd7);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        run_op(ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        run_op(ALU_DIVU, 32'd5, 32'd0, 5'd10);
        run_op(ALU_MODU, 32'd5, 32'd0, 5'd11);
        run_op(ALU_DIV, 32'hFFFF_FFFB, 32'd0, 5'd12);
        run_op(ALU_MOD, 32'hFFFF_FFFB, 32'd0, 5'd13);

        // Flush on the 10th ITER cycle discards the operation.
        apply_stimulus(ALU_DIVU, 32'd1000, 32'd3, 5'd14);
        repeat (10) begin @(posedge aclk); #1; end
        check_output("busy_before_flush", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge aclk); #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        check_output("flush_busy", {31'd0, busy}, 32'd0);
        check_output("flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (40) @(posedge aclk);
        #1;
        run_op(ALU_DIVU, 32'd9, 32'd3, 5'd15);

        in_valid = 1'b1;
        flush    = 1'b1;
        op       = ALU_DIVU;
        src1     = 32'd50;
        src2     = 32'd5;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_output("flush_idle_busy", {31'd0, busy}, 32'd0);
        check_output("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Consumer stalls in DONE; outputs must hold.
        out_ready = 1'b0;
        apply_stimulus(ALU_DIV, 32'hFFFF_FF9C, 32'd7, 5'd21);
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin @(posedge aclk); #1; n++; end
        check_output("hold_reached_done", {31'd0, out_valid}, 32'd1);
        repeat (5) begin
            @(posedge aclk); #1;
            check_output("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check_output("hold_result", result, 32'hFFFF_FFF2);
            check_output("hold_out_rd_no", {27'd0, out_rd_no}, 32'd21);
            check_output("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge aclk); #1;
        check_output("release_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-ITER clears everything on the next edge.
        apply_stimulus(ALU_MODU, 32'd77, 32'd10, 5'd22);
        repeat (15) begin @(posedge aclk); #1; end
        reset = 1'b1;
        @(posedge aclk); #1;
        reset = 1'b0;
        void'(exp_q.pop_back());
        check_output("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("midrst_busy", {31'd0, busy}, 32'd0);
        check_output("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("midrst_result", result, 32'd0);
        check_output("midrst_out_rd_no", {27'd0, out_rd_no}, 32'd0);

        in_valid = 1'b1;
        op       = ALU_ADD;
        src1     = 32'd8;
        src2     = 32'd2;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        check_output("illegal_busy", {31'd0, busy}, 32'd0);
        check_output("illegal_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       rop = ALU_DIV;
                1:       rop = ALU_MOD;
                2:       rop = ALU_DIVU;
                default: rop = ALU_MODU;
            endcase
            apply_stimulus(rop, pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));
            wait_idle(1'b1);
        end

        repeat (5) @(posedge aclk);
        #1;
        check_output("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
